word_mem_arbiter: RTL and testbench
===================================

// Module: word_mem_arbiter
// PURPOSE
//  Round-robin access arbiter sitting directly upstream of the shared word memory (1024 x 8 bit).
//  Collects read/write requests from NUM_CORES PLC cores over a req/ack handshake.
//  Serialises them onto the single memory port (chip_enable/WriteEnable/Addr/InputData).
//  Returns registered read data to the granted core, so the memory's tri-state output never reaches a core.
// PARAMETERS
//  NUM_CORES  4   number of requesting cores (2..8)
//  ADDR_BITS  10  memory address width
//  DATA_BITS  8   memory word width
//  GNT_W      $clog2(NUM_CORES)  localparam, grant index width
// PORTS
//  clk              in   1                   single clock, all logic on posedge
//  rst              in   1                   synchronous, active-high reset
//  core_req         in   NUM_CORES           per-core request, level
//  core_we          in   NUM_CORES           per-core 1=write 0=read, valid with req
//  core_addr        in   NUM_CORES*ADDR_BITS packed, core i at [i*ADDR_BITS +: ADDR_BITS]
//  core_wdata       in   NUM_CORES*DATA_BITS packed, core i at [i*DATA_BITS +: DATA_BITS]
//  core_lock        in   NUM_CORES           hold-grant request (only with WORD_ARB_LOCK_EN)
//  core_ack         out  NUM_CORES           one-hot, 1-cycle completion pulse
//  core_rdata       out  DATA_BITS           shared read-data bus, valid when the matching ack=1
//  mem_chip_enable  out  1                   to memory chip_enable
//  mem_enable       out  1                   to memory enable, equal to mem_chip_enable
//  mem_we           out  1                   to memory WriteEnable
//  mem_addr         out  ADDR_BITS           to memory Addr
//  mem_wdata        out  DATA_BITS           to memory InputData
//  mem_rdata        in   DATA_BITS           from memory OutputData (combinational, Z when CE=0)
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE. Every state lasts exactly 1 cycle, except IDLE, which lasts until any req is present.
//  - IDLE:
//    - All mem_* outputs are 0.
//    - If |core_req: pick the first requesting core searching from last_gnt+1 upward, modulo NUM_CORES.
//    - Latch gnt, we, addr and wdata of that core into internal regs, then go to ACCESS.
//  - ACCESS:
//    - mem_chip_enable = mem_enable = 1.
//    - mem_addr and mem_wdata are driven from the latched regs; mem_we = latched we.
//    - A write commits in the memory on the closing edge.
//    - A read captures mem_rdata into the rdata register on the closing edge.
//  - RESP:
//    - core_ack[gnt] = 1; core_rdata = captured word (holds the previous value after a write).
//    - last_gnt <= gnt; go to IDLE.
//  - Latency: req seen in IDLE at cycle 0 -> ack in cycle 2. Peak throughput is 1 access per 3 cycles.
//  - Handshake:
//    - req is sampled only in IDLE; changes to req/we/addr/wdata after the grant are ignored.
//    - A core must drop req in the cycle after ack, or be rearbitrated as a new request.
//  - Fairness: after core i is served, core i has lowest priority. No core waits more than NUM_CORES grants.
//  - core_rdata holds its value between reads; it never carries Z or X after reset.
//  - Reset values:
//    - state=IDLE; last_gnt=NUM_CORES-1, so core 0 wins the first tie.
//    - core_ack=0, core_rdata=0, all mem_*=0.
//  - Reset during ACCESS: the memory write at that edge still occurs (the memory has no reset). No ack is issued; the FSM enters IDLE.
//  - Reset during RESP: the ack is suppressed that cycle; the core must re-request.
//  - Simultaneous requests from all cores are served in strict rotation.
// CONFIGURATION
//  WORD_ARB_LOCK_EN defined:
//    - core_lock port present.
//    - If core_lock[gnt]=1 in RESP, the next IDLE considers only that core (others are masked) for as long as its lock stays high.
//    - This enables atomic read-modify-write.
//    - When the lock drops, the next IDLE resumes normal round-robin from last_gnt+1.
//    - If the locked core has no req in IDLE, the FSM stays in IDLE (others are still blocked) until req or lock drops.
//  WORD_ARB_LOCK_EN undefined: core_lock port absent; pure round-robin, no masking logic.
// TESTING
//  - Single write: core 1 req, we=1, addr=0x155, wdata=0xA5 -> mem_we=1 with mem_addr=0x155 in cycle 1; core_ack=4'b0010 in cycle 2.
//  - Read-back: core 2 reads 0x155 -> core_ack=4'b0100, core_rdata=0xA5 in the ack cycle; mem_we=0 throughout.
//  - Contention: all 4 cores request continuously, each dropping req for 1 cycle after its ack -> grant order 0,1,2,3,0; acks spaced 3 cycles apart.
//  - Reset mid-ACCESS: rst=1 in the ACCESS cycle of a write of 0x3C to 0x3FF -> no ack; FSM in IDLE; a later read of 0x3FF returns 0x3C.
//  - Lock (WORD_ARB_LOCK_EN): core 3 reads then writes with lock=1 while core 0 requests -> core 3 is served twice consecutively; core 0 is acked only after lock=0.

Source files
------------

// File: rtl/word_mem_arbiter.sv
// Round-robin arbiter serialising NUM_CORES req/ack masters onto one word memory port.
// Optional WORD_ARB_LOCK_EN adds core_lock for atomic read-modify-write sequences.
module word_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_we,
  input  logic [NUM_CORES*ADDR_BITS-1:0] core_addr,
  input  logic [NUM_CORES*DATA_BITS-1:0] core_wdata,
`ifdef WORD_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]           core_lock,
`endif
  output logic [NUM_CORES-1:0]           core_ack,
  output logic [DATA_BITS-1:0]           core_rdata,
  output logic                           mem_chip_enable,
  output logic                           mem_enable,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_wdata,
  input  logic [DATA_BITS-1:0]           mem_rdata
);

  localparam int GNT_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [GNT_W-1:0]       gnt_q, gnt_d;
  logic [GNT_W-1:0]       last_gnt_q, last_gnt_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic                   ce_q, ce_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;

  logic [NUM_CORES-1:0]   eff_req;
  logic [GNT_W-1:0]       pick;
  logic                   found;
  logic                   lock_hold;

`ifdef WORD_ARB_LOCK_EN
  logic                   lock_q, lock_d;
`endif

  // Hold mask: while the last served core keeps its lock, only it may win.
  always_comb begin
    lock_hold = 1'b0;
`ifdef WORD_ARB_LOCK_EN
    lock_hold = lock_q & core_lock[last_gnt_q];
`endif
    if (lock_hold) begin
      eff_req = core_req & (NUM_CORES'(1) << last_gnt_q);
    end else begin
      eff_req = core_req;
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!found && eff_req[(int'(last_gnt_q) + k) % NUM_CORES]) begin
        found = 1'b1;
        pick  = GNT_W'((int'(last_gnt_q) + k) % NUM_CORES);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    ce_d       = ce_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef WORD_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef WORD_ARB_LOCK_EN
        if (lock_q && !core_lock[last_gnt_q]) begin
          lock_d = 1'b0;
        end
`endif
        if (found) begin
          state_d = S_ACCESS;
          gnt_d   = pick;
          ce_d    = 1'b1;
          we_d    = core_we[pick];
          addr_d  = core_addr[pick*ADDR_BITS +: ADDR_BITS];
          wdata_d = core_wdata[pick*DATA_BITS +: DATA_BITS];
        end
      end
      S_ACCESS: begin
        state_d      = S_RESP;
        ack_d[gnt_q] = 1'b1;
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        ce_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
      S_RESP: begin
        state_d    = S_IDLE;
        last_gnt_d = gnt_q;
`ifdef WORD_ARB_LOCK_EN
        lock_d     = core_lock[gnt_q];
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GNT_W'(NUM_CORES - 1);
      ack_q      <= '0;
      rdata_q    <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef WORD_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef WORD_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  // A reset arriving in the response cycle withdraws the pending ack.
  assign core_ack        = ack_q & {NUM_CORES{~rst}};
  assign core_rdata      = rdata_q;
  assign mem_chip_enable = ce_q;
  assign mem_enable      = ce_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_word_mem_arbiter.sv
// Directed bench for word_mem_arbiter with a behavioural 1024x8 word memory.
// Expected acks are queued when requests are driven and checked as acks arrive.
module tb_word_mem_arbiter;

  localparam int N  = 4;
  localparam int AB = 10;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    core_req, core_we, core_lock;
  logic [N*AB-1:0] core_addr;
  logic [N*DB-1:0] core_wdata;
  wire  [N-1:0]    core_ack;
  wire  [DB-1:0]   core_rdata;
  wire             mem_ce, mem_en, mem_we;
  wire  [AB-1:0]   mem_addr;
  wire  [DB-1:0]   mem_wdata;
  wire  [DB-1:0]   mem_rdata;

  word_mem_arbiter #(.NUM_CORES(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
`ifdef WORD_ARB_LOCK_EN
    .core_lock(core_lock),
`endif
    .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_chip_enable(mem_ce), .mem_enable(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [DB-1:0] mem [1024];
  always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_ce ? mem[mem_addr] : 'z;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            core;
    logic [DB-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(int i, logic we, logic [AB-1:0] a, logic [DB-1:0] d);
    core_we[i]            = we;
    core_addr[i*AB +: AB] = a;
    core_wdata[i*DB +: DB] = d;
  endtask

  task automatic push(int c, logic [DB-1:0] d);
    exp_t e;
    e.core  = c;
    e.rdata = d;
    sb.push_back(e);
  endtask

  function automatic int ack_index();
    int w = -1;
    for (int j = 0; j < N; j++) if (core_ack[j]) w = j;
    return w;
  endfunction

  task automatic pop_check(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected_ack"}, core_ack, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_ack"}, core_ack, 32'(1) << e.core);
      check({tag, "_rdata"}, core_rdata, e.rdata);
    end
  endtask

  task automatic wait_ack(string tag, output int who);
    who = -1;
    for (int t = 0; t < 20 && who < 0; t++) begin
      tick();
      if (|core_ack) who = ack_index();
    end
    if (who < 0) check({tag, "_ack_timeout"}, 0, 1);
    else pop_check(tag);
  endtask

  task automatic single(string tag, int c, logic we, logic [AB-1:0] a,
                        logic [DB-1:0] d, logic [DB-1:0] exp_rd);
    int who;
    set_core(c, we, a, d);
    core_req[c] = 1'b1;
    push(c, exp_rd);
    tick();
    core_req[c] = 1'b0;
    wait_ack(tag, who);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int nacks;
    int last_ack;
    int t0;
    int first3;
    int reraise [N];

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst        = 1'b1;
    core_req   = '0;
    core_we    = '0;
    core_lock  = '0;
    core_addr  = '0;
    core_wdata = '0;
    repeat (3) tick();
    check("rst_ack", core_ack, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_ce", mem_ce, 0);
    check("rst_en", mem_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    rst = 1'b0;
    tick();

    // single write by core 1
    set_core(1, 1'b1, 10'h155, 8'hA5);
    core_req[1] = 1'b1;
    push(1, 8'h00);
    tick();
    core_req[1] = 1'b0;
    set_core(1, 1'b0, 10'h0AA, 8'h11);
    check("wr_ce", mem_ce, 1);
    check("wr_en", mem_en, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 10'h155);
    check("wr_wdata", mem_wdata, 8'hA5);
    check("wr_no_early_ack", core_ack, 0);
    tick();
    pop_check("wr");
    tick();
    check("wr_ack_pulse", core_ack, 0);
    check("wr_idle_ce", mem_ce, 0);

    // read-back by core 2
    set_core(2, 1'b0, 10'h155, 8'h00);
    core_req[2] = 1'b1;
    push(2, 8'hA5);
    tick();
    core_req[2] = 1'b0;
    check("rd_ce", mem_ce, 1);
    check("rd_we", mem_we, 0);
    check("rd_addr", mem_addr, 10'h155);
    tick();
    check("rd_resp_we", mem_we, 0);
    pop_check("rd");
    tick();

    // reset in the response cycle of a read by core 3
    set_core(3, 1'b0, 10'h155, 8'h00);
    core_req[3] = 1'b1;
    tick();
    core_req[3] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("resp_rst_ack", core_ack, 0);
    tick();
    rst = 1'b0;
    check("resp_rst_rdata", core_rdata, 0);
    tick();

    // reset in the access cycle of a write by core 0
    set_core(0, 1'b1, 10'h3FF, 8'h3C);
    core_req[0] = 1'b1;
    tick();
    check("acc_rst_ce", mem_ce, 1);
    check("acc_rst_addr", mem_addr, 10'h3FF);
    rst = 1'b1;
    core_req[0] = 1'b0;
    tick();
    rst = 1'b0;
    who = 0;
    for (int t = 0; t < 4; t++) begin
      if (|core_ack || mem_ce) who = 1;
      tick();
    end
    check("acc_rst_quiet", who, 0);
    check("acc_rst_mem", mem[10'h3FF], 8'h3C);

    // contention: all cores, each dropping req for one cycle after ack
    set_core(0, 1'b0, 10'h3FF, 8'h00);
    set_core(1, 1'b0, 10'h155, 8'h00);
    set_core(2, 1'b0, 10'h010, 8'h00);
    set_core(3, 1'b0, 10'h155, 8'h00);
    push(0, 8'h3C);
    push(1, 8'hA5);
    push(2, 8'h00);
    push(3, 8'hA5);
    push(0, 8'h3C);
    for (int j = 0; j < N; j++) reraise[j] = -1;
    core_req = '1;
    t0       = cyc;
    nacks    = 0;
    last_ack = 0;
    for (int t = 0; t < 40 && nacks < 5; t++) begin
      tick();
      for (int j = 0; j < N; j++) if (reraise[j] == cyc) core_req[j] = 1'b1;
      if (|core_ack) begin
        who = ack_index();
        pop_check("cont");
        if (nacks == 0) check("cont_latency", cyc - t0, 2);
        else check("cont_spacing", cyc - last_ack, 3);
        last_ack      = cyc;
        nacks++;
        core_req[who] = 1'b0;
        reraise[who]  = cyc + 2;
      end
    end
    check("cont_count", nacks, 5);
    core_req = '0;
    tick();
    tick();

    // core 3 read then write under lock while core 0 waits
    set_core(3, 1'b0, 10'h155, 8'h00);
    set_core(0, 1'b1, 10'h020, 8'h77);
    core_lock[3] = 1'b1;
    core_req[3]  = 1'b1;
    core_req[0]  = 1'b1;
`ifdef WORD_ARB_LOCK_EN
    push(3, 8'hA5);
    push(3, 8'hA5);
    push(0, 8'hA5);
`else
    push(3, 8'hA5);
    push(0, 8'hA5);
    push(3, 8'hA5);
`endif
    first3 = 1;
    for (int n = 0; n < 3; n++) begin
      wait_ack("lock", who);
      if (who == 3 && first3 == 1) begin
        set_core(3, 1'b1, 10'h155, 8'h5A);
        first3 = 0;
      end else if (who == 3) begin
        core_lock[3] = 1'b0;
        core_req[3]  = 1'b0;
      end else if (who == 0) begin
        core_req[0] = 1'b0;
      end
    end
    core_req  = '0;
    core_lock = '0;
    tick();
    tick();

    single("rb_lockwr", 1, 1'b0, 10'h155, 8'h00, 8'h5A);
    single("rb_core0wr", 2, 1'b0, 10'h020, 8'h00, 8'h77);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
